// File: rtl/chimera_pmu_pkg.sv
// Shared types and helpers for the Chimera per-cluster power sequencer.
package chimera_pmu_pkg;

    typedef enum logic [2:0] {
        PMU_OFF,
        PMU_UP_RST,
        PMU_UP_DEISO,
        PMU_ON,
        PMU_DN_ISO,
        PMU_DN_RST
    } pmu_state_e;

    typedef struct packed {
        logic rst_n;
        logic iso;
        logic busy;
        logic pwr_on;
    } pmu_drive_t;

    typedef struct packed {
        logic busy;
        logic done;
        logic timeout;
        logic rst_n;
        logic iso;
        logic pwr_on;
    } pmu_status_t;

    function automatic int unsigned pmu_cnt_width(input int unsigned rst_hold,
                                                  input int unsigned ack_timeout);
        int unsigned longest;
        longest = (rst_hold > ack_timeout) ? rst_hold : ack_timeout;
        return $clog2(longest + 1);
    endfunction

    function automatic bit pmu_params_legal(input int unsigned num_clusters,
                                            input int unsigned rst_hold,
                                            input int unsigned ack_timeout);
        return (num_clusters >= 1) && (rst_hold >= 1) && (ack_timeout >= 1);
    endfunction

    function automatic pmu_drive_t pmu_decode(input pmu_state_e state);
        pmu_drive_t d;
        d = '{rst_n: 1'b0, iso: 1'b1, busy: 1'b0, pwr_on: 1'b0};
        case (state)
            PMU_UP_RST:   d.busy = 1'b1;
            PMU_UP_DEISO: d = '{rst_n: 1'b1, iso: 1'b0, busy: 1'b1, pwr_on: 1'b0};
            PMU_ON:       d = '{rst_n: 1'b1, iso: 1'b0, busy: 1'b0, pwr_on: 1'b1};
            PMU_DN_ISO:   d = '{rst_n: 1'b1, iso: 1'b1, busy: 1'b1, pwr_on: 1'b0};
            PMU_DN_RST:   d.busy = 1'b1;
            default:      ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/chimera_pmu_cluster_fsm.sv
// Power sequencing FSM for a single cluster: isolate/reset/release/de-isolate ordering.
module chimera_pmu_cluster_fsm
    import chimera_pmu_pkg::*;
#(
    parameter bit          BootOn        = 1'b1,
    parameter int unsigned RstHoldCycles = 4,
    parameter int unsigned AckTimeout    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        dir_on,
    input  logic        iso_ack,
    input  logic        clr_timeout,
    output pmu_status_t status
);

    localparam int unsigned         CntWidth  = pmu_cnt_width(RstHoldCycles, AckTimeout);
    localparam logic [CntWidth-1:0] HoldLast  = CntWidth'(RstHoldCycles - 1);
    localparam logic [CntWidth-1:0] AckLast   = CntWidth'(AckTimeout - 1);
    localparam pmu_state_e          BootState = BootOn ? PMU_ON : PMU_OFF;

    pmu_state_e          state;
    pmu_drive_t          drive;
    logic [CntWidth-1:0] cnt;
    logic                done_q;
    logic                timeout_q;

    // Outputs are decoded from the next state so they register together with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BootState;
            drive     <= pmu_decode(BootState);
            cnt       <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (cnt != '1) cnt <= cnt + 1'b1;
            if (clr_timeout) timeout_q <= 1'b0;
            case (state)
                PMU_OFF, PMU_ON: begin
                    if (start) begin
                        if (dir_on == (state == PMU_ON)) begin
                            done_q <= 1'b1;
                        end else if (dir_on) begin
                            state <= PMU_UP_RST;
                            drive <= pmu_decode(PMU_UP_RST);
                            cnt   <= '0;
                        end else begin
                            state <= PMU_DN_ISO;
                            drive <= pmu_decode(PMU_DN_ISO);
                            cnt   <= '0;
                        end
                    end
                end
                PMU_UP_RST: begin
                    if (cnt == HoldLast) begin
                        state <= PMU_UP_DEISO;
                        drive <= pmu_decode(PMU_UP_DEISO);
                        cnt   <= '0;
                    end
                end
                PMU_UP_DEISO: begin
                    if (!iso_ack || cnt == AckLast) begin
                        state  <= PMU_ON;
                        drive  <= pmu_decode(PMU_ON);
                        done_q <= 1'b1;
                        if (iso_ack) timeout_q <= 1'b1;
                    end
                end
                PMU_DN_ISO: begin
                    if (iso_ack || cnt == AckLast) begin
                        state <= PMU_DN_RST;
                        drive <= pmu_decode(PMU_DN_RST);
                        cnt   <= '0;
                        if (!iso_ack) timeout_q <= 1'b1;
                    end
                end
                PMU_DN_RST: begin
                    if (cnt == HoldLast) begin
                        state  <= PMU_OFF;
                        drive  <= pmu_decode(PMU_OFF);
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state <= BootState;
                    drive <= pmu_decode(BootState);
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign status = '{busy:    drive.busy,
                      done:    done_q,
                      timeout: timeout_q,
                      rst_n:   drive.rst_n,
                      iso:     drive.iso,
                      pwr_on:  drive.pwr_on};

endmodule

// File: rtl/chimera_pmu_seq.sv
// Chimera power-management sequencer: request decode plus one sequencing FSM per cluster.
module chimera_pmu_seq
    import chimera_pmu_pkg::*;
#(
    parameter int unsigned            NumClusters   = 5,
    parameter logic [NumClusters-1:0] BootOnMask    = '1,
    parameter int unsigned            RstHoldCycles = 4,
    parameter int unsigned            AckTimeout    = 16,
    parameter int unsigned            IdxWidth      = (NumClusters > 1) ? $clog2(NumClusters) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [IdxWidth-1:0]    req_cluster_i,
    input  logic                   req_pwr_on_i,
    input  logic [NumClusters-1:0] iso_ack_i,
    output logic [NumClusters-1:0] rst_clusters_no,
    output logic [NumClusters-1:0] iso_en_o,
    output logic [NumClusters-1:0] pwr_on_o,
    output logic [NumClusters-1:0] busy_o,
    output logic [NumClusters-1:0] done_o,
    output logic [NumClusters-1:0] timeout_o,
    input  logic [NumClusters-1:0] clr_timeout_i
);

    if (!pmu_params_legal(NumClusters, RstHoldCycles, AckTimeout)) begin : g_bad_params
        $error("chimera_pmu_seq: NumClusters, RstHoldCycles and AckTimeout must all be >= 1");
    end

    logic                   idx_valid;
    logic [NumClusters-1:0] start;

    // Out-of-range indices are always ready so a stray request cannot stall the port.
    assign idx_valid   = (32'(req_cluster_i) < NumClusters);
    assign req_ready_o = idx_valid ? !busy_o[req_cluster_i] : 1'b1;

    for (genvar i = 0; i < NumClusters; i++) begin : g_cluster
        pmu_status_t status;

        assign start[i] = req_valid_i && req_ready_o && idx_valid &&
                          (req_cluster_i == IdxWidth'(i));

        chimera_pmu_cluster_fsm #(
            .BootOn        (BootOnMask[i]),
            .RstHoldCycles (RstHoldCycles),
            .AckTimeout    (AckTimeout)
        ) u_fsm (
            .clk         (clk_i),
            .rst         (rst_i),
            .start       (start[i]),
            .dir_on      (req_pwr_on_i),
            .iso_ack     (iso_ack_i[i]),
            .clr_timeout (clr_timeout_i[i]),
            .status      (status)
        );

        assign rst_clusters_no[i] = status.rst_n;
        assign iso_en_o[i]        = status.iso;
        assign pwr_on_o[i]        = status.pwr_on;
        assign busy_o[i]          = status.busy;
        assign done_o[i]          = status.done;
        assign timeout_o[i]       = status.timeout;
    end

endmodule
